jk_bank_arbiter: RTL and testbench

- Shares one bank of N_FF JK flip-flops among N_REQ requesters.
- Each requester issues a command (hold, reset, set or toggle) to one flip-flop of the bank.
- A round-robin arbiter grants one requester per cycle. The winning command is applied to the addressed jk_cell on the following edge.
- The block is the controller layer above the individual JK flip-flop cells.

---
 rtl/jk_pkg.sv | 28 ++
 rtl/jk_cell.sv | 24 ++
 rtl/jk_bank_arbiter.sv | 112 +++++++++++
 tb/tb_jk_bank_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared command encoding and decode helper for the JK bank arbiter.
package jk_pkg;

  typedef logic [1:0] cmd_t;

  localparam cmd_t JK_HOLD   = 2'b00;
  localparam cmd_t JK_RESET  = 2'b01;
  localparam cmd_t JK_SET    = 2'b10;
  localparam cmd_t JK_TOGGLE = 2'b11;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

  // Map a requester command onto the J/K inputs of one flip-flop.
  function automatic jk_t jk_decode(input cmd_t c);
    jk_t r;
    case (c)
      JK_RESET:  r = '{j: 1'b0, k: 1'b1};
      JK_SET:    r = '{j: 1'b1, k: 1'b0};
      JK_TOGGLE: r = '{j: 1'b1, k: 1'b1};
      default:   r = '{j: 1'b0, k: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset to 0.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // Classic JK next-state: hold, reset, set, toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a bank of JK flip-flops among requesters.
// Stage 1 grants one requester per edge and latches its command; stage 2
// applies the latched command to the addressed cell on the following edge.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N_FF  = 8,
  parameter int AW    = (N_FF > 1) ? $clog2(N_FF) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   cmd,
  input  logic [AW*N_REQ-1:0]  addr,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_FF-1:0]      q,
  output logic                 busy,
  output logic                 err
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [AW:0] FF_LIMIT = (AW+1)'(N_FF);

  logic [PW-1:0]    rr_ptr;
  logic [N_REQ-1:0] eligible;
  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [N_REQ-1:0] win_onehot;
  cmd_t             win_cmd;
  logic [AW-1:0]    win_addr;
  logic [PW-1:0]    rr_next;
  int               idx;

  cmd_t             pend_cmd;
  logic [AW-1:0]    pend_addr;
  logic             pend_in_range;
  jk_t              pend_jk;
  logic [N_FF-1:0]  cell_j;
  logic [N_FF-1:0]  cell_k;

  // Pick the first eligible requester starting from the round-robin pointer.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    eligible   = req & ~gnt;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_cmd    = JK_HOLD;
    win_addr   = '0;
    idx        = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % N_REQ;
      if (!win_found && eligible[idx]) begin
        win_found       = 1'b1;
        win_idx         = PW'(idx);
        win_onehot[idx] = 1'b1;
        win_cmd         = cmd_t'(cmd[2*idx +: 2]);
        win_addr        = addr[AW*idx +: AW];
      end
    end
    rr_next = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // Stage 1 grant/latch registers and the stage 2 error pulse.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  // NOTE: the pending command registers are reset so a reset discards it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      rr_ptr    <= '0;
      pend_cmd  <= JK_HOLD;
      pend_addr <= '0;
    end else begin
      gnt  <= win_onehot;
      busy <= win_found;
      err  <= busy && !pend_in_range;
      if (win_found) begin
        pend_cmd  <= win_cmd;
        pend_addr <= win_addr;
        rr_ptr    <= rr_next;
      end
    end
  end

  // Drive only the addressed cell from the pending command; others hold.
  always_comb begin
    pend_in_range = ({1'b0, pend_addr} < FF_LIMIT);
    pend_jk       = jk_decode(pend_cmd);
    cell_j        = '0;
    cell_k        = '0;
    for (int i = 0; i < N_FF; i++) begin
      if (busy && pend_in_range && pend_addr == AW'(i)) begin
        cell_j[i] = pend_jk.j;
        cell_k[i] = pend_jk.k;
      end
    end
  end

  for (genvar i = 0; i < N_FF; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (cell_j[i]),
      .k   (cell_k[i]),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: an 8-cell bank and a 6-cell bank.
module tb_jk_bank_arbiter;
  import jk_pkg::*;

  logic        clk;
  logic        rst;

  logic [3:0]  req;
  logic [7:0]  cmd;
  logic [11:0] addr;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        busy;
  logic        err;

  logic [3:0]  req6;
  logic [7:0]  cmd6;
  logic [11:0] addr6;
  logic [3:0]  gnt6;
  logic [5:0]  q6;
  logic        busy6;
  logic        err6;

  int checks   = 0;
  int failures = 0;

  jk_bank_arbiter #(.N_REQ(4), .N_FF(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .cmd  (cmd),
    .addr (addr),
    .gnt  (gnt),
    .q    (q),
    .busy (busy),
    .err  (err)
  );

  jk_bank_arbiter #(.N_REQ(4), .N_FF(6)) dut6 (
    .clk  (clk),
    .rst  (rst),
    .req  (req6),
    .cmd  (cmd6),
    .addr (addr6),
    .gnt  (gnt6),
    .q    (q6),
    .busy (busy6),
    .err  (err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst   = 1'b0;
    req   = 4'b1111;
    cmd   = '0;
    addr  = '0;
    req6  = 4'b0000;
    cmd6  = '0;
    addr6 = '0;

    // Reset held across three edges with all requests high.
    tick(); tick(); tick();
    check("rst_gnt",  gnt,  4'b0000);
    check("rst_q",    q,    8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err",  err,  1'b0);
    check("rst_q6",   q6,   6'h00);

    // First grant after release goes to requester 0.
    rst = 1'b1;
    tick();
    check("first_gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    check("idle_gnt", gnt, 4'b0000);

    // Single SET from requester 1 to cell 3.
    req = 4'b0010;
    cmd[3:2]  = JK_SET;
    addr[5:3] = 3'd3;
    tick();
    check("set_gnt",  gnt,  4'b0010);
    check("set_busy", busy, 1'b1);
    check("set_q_k",  q,    8'h00);
    req = 4'b0000;
    tick();
    check("set_q_k1",   q,   8'h08);
    check("set_gnt_k1", gnt, 4'b0000);
    tick();
    check("set_busy_k2", busy, 1'b0);

    // Requester 0 toggles cell 5 twice.
    req = 4'b0001;
    cmd[1:0]  = JK_TOGGLE;
    addr[2:0] = 3'd5;
    tick();
    check("tog1_gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    check("tog1_q",   q,   8'h28);
    check("tog1_err", err, 1'b0);
    req = 4'b0001;
    tick();
    check("tog2_gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    check("tog2_q",   q,   8'h08);
    check("tog2_err", err, 1'b0);

    // Asynchronous reset clears the bank without a clock edge.
    rst = 1'b0;
    #2;
    check("async_q", q, 8'h00);
    rst = 1'b1;

    // Round robin with all requesters continuously asking, all HOLD.
    cmd  = '0;
    addr = '0;
    req  = 4'b1111;
    tick(); check("rr0", gnt, 4'b0001);
    tick(); check("rr1", gnt, 4'b0010);
    tick(); check("rr2", gnt, 4'b0100);
    tick(); check("rr3", gnt, 4'b1000);
    tick(); check("rr4", gnt, 4'b0001);
    check("rr_q", q, 8'h00);
    req = 4'b0000;
    tick(); tick();

    // Same-target conflict: req0 SET cell 2, req1 RESET cell 2.
    pulse_reset();
    cmd[1:0]  = JK_SET;
    addr[2:0] = 3'd2;
    cmd[3:2]  = JK_RESET;
    addr[5:3] = 3'd2;
    req = 4'b0011;
    tick();
    check("cf_gnt0", gnt, 4'b0001);
    req = 4'b0010;
    tick();
    check("cf_gnt1", gnt, 4'b0010);
    check("cf_q1",   q,   8'h04);
    req = 4'b0000;
    tick();
    check("cf_q2", q, 8'h00);

    // Mid-operation reset discards the pending SET to cell 1.
    req = 4'b0100;
    cmd[5:4]  = JK_SET;
    addr[8:6] = 3'd1;
    tick();
    check("mid_gnt",  gnt,  4'b0100);
    check("mid_busy", busy, 1'b1);
    rst = 1'b0;
    #2;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_gnt",  gnt,  4'b0000);
    rst = 1'b1;
    req = 4'b0000;
    tick();
    check("mid_q",    q,    8'h00);
    check("mid_busy2", busy, 1'b0);

    // Six-cell bank: out-of-range address raises err, bank unchanged.
    req6 = 4'b0100;
    cmd6[5:4]  = JK_SET;
    addr6[8:6] = 3'd7;
    tick();
    check("oor_gnt", gnt6, 4'b0100);
    check("oor_err0", err6, 1'b0);
    req6 = 4'b0000;
    tick();
    check("oor_err1", err6, 1'b1);
    check("oor_q",    q6,   6'h00);
    tick();
    check("oor_err2", err6, 1'b0);

    // Six-cell bank: in-range SET to cell 5 still works.
    req6 = 4'b0001;
    cmd6[1:0]  = JK_SET;
    addr6[2:0] = 3'd5;
    tick();
    check("in6_gnt", gnt6, 4'b0001);
    req6 = 4'b0000;
    tick();
    check("in6_q",   q6,   6'h20);
    check("in6_err", err6, 1'b0);
    check("main_err_quiet", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
